// File: rtl/neuron_layer_loader.sv
// neuron_layer_loader: write-side driver for a neuron layer register file.
// Takes a valid/ready stream of neuron values and emits one registered write strobe per
// accepted value. Addresses run 0..LAYER_SZ-1 and restart at 0 on every start. A one-cycle
// layer clear can optionally be issued before the first write.
//
// Ports:
//   clk_i            clock, all state on rising edge
//   rst_ni           asynchronous active-low reset
//   start_i          begin a load pass (only honoured while idle)
//   clear_first_i    sampled with start_i; 1 = pulse layer_reset_o before loading
//   in_valid_i       upstream value valid
//   in_data_i        upstream neuron value
//   in_ready_o       loader accepts in_data_i this cycle
//   layer_reset_o    one-cycle clear strobe to the layer
//   load_en_o        write strobe to the layer
//   load_value_o     value written (held while load_en_o is low)
//   load_address_o   write index, zero-extended count (held while load_en_o is low)
//   busy_o           high whenever a pass is in progress
//   done_o           one-cycle pulse, coincident with the final write
module neuron_layer_loader #(
  parameter int unsigned SIZE     = 16,
  parameter int unsigned LAYER_SZ = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            clear_first_i,
  input  logic            in_valid_i,
  input  logic [SIZE-1:0] in_data_i,
  output logic            in_ready_o,
  output logic            layer_reset_o,
  output logic            load_en_o,
  output logic [SIZE-1:0] load_value_o,
  output logic [SIZE-1:0] load_address_o,
  output logic            busy_o,
  output logic            done_o
);

  // One extra bit so the count can represent LAYER_SZ itself without overflow.
  localparam int unsigned    CntW    = $clog2(LAYER_SZ) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(LAYER_SZ - 1);

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StLoad,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            layer_reset_q, layer_reset_d;
  logic            load_en_q, load_en_d;
  logic            done_q, done_d;
  logic [SIZE-1:0] value_q, value_d;
  logic [SIZE-1:0] addr_q, addr_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    layer_reset_d = 1'b0;
    load_en_d     = 1'b0;
    done_d        = 1'b0;
    value_d       = value_q;
    addr_d        = addr_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          cnt_d = '0;
          if (clear_first_i) begin
            state_d       = StClear;
            layer_reset_d = 1'b1;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StClear: begin
        state_d = StLoad;
      end
      StLoad: begin
        // in_ready_o is high for the whole of this state, so valid alone means accept.
        if (in_valid_i) begin
          load_en_d            = 1'b1;
          value_d              = in_data_i;
          addr_d               = '0;
          addr_d[CntW-1:0]     = cnt_q;
          cnt_d                = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      layer_reset_q <= 1'b0;
      load_en_q     <= 1'b0;
      done_q        <= 1'b0;
      value_q       <= '0;
      addr_q        <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      layer_reset_q <= layer_reset_d;
      load_en_q     <= load_en_d;
      done_q        <= done_d;
      value_q       <= value_d;
      addr_q        <= addr_d;
    end
  end

  assign in_ready_o     = (state_q == StLoad);
  assign busy_o         = (state_q != StIdle);
  assign layer_reset_o  = layer_reset_q;
  assign load_en_o      = load_en_q;
  assign done_o         = done_q;
  assign load_value_o   = value_q;
  assign load_address_o = addr_q;

endmodule

// File: tb/tb_neuron_layer_loader.sv
// Self-checking bench for neuron_layer_loader. Four instances with layer sizes 4, 2, 3 and 1
// share one input stream; a pass-level reference model (accept count per pass, pending clear,
// last write) predicts every output of every instance on every cycle.
module tb_neuron_layer_loader;

  localparam int unsigned SIZE = 16;
  localparam int unsigned NDut = 4;
  localparam int unsigned LayerSzs [NDut] = '{4, 2, 3, 1};

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            clr;
  logic            vld;
  logic [SIZE-1:0] data;

  logic            rdy  [NDut];
  logic            lrst [NDut];
  logic            len  [NDut];
  logic            bsy  [NDut];
  logic            dn   [NDut];
  logic [SIZE-1:0] val  [NDut];
  logic [SIZE-1:0] adr  [NDut];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDut; g++) begin : g_dut
    neuron_layer_loader #(
      .SIZE    (SIZE),
      .LAYER_SZ(LayerSzs[g])
    ) u_dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .start_i       (start),
      .clear_first_i (clr),
      .in_valid_i    (vld),
      .in_data_i     (data),
      .in_ready_o    (rdy[g]),
      .layer_reset_o (lrst[g]),
      .load_en_o     (len[g]),
      .load_value_o  (val[g]),
      .load_address_o(adr[g]),
      .busy_o        (bsy[g]),
      .done_o        (dn[g])
    );
  end

  // Reference model: per instance, whether a pass is running, whether the clear cycle is
  // still pending, how many values were accepted this pass, and the most recent write.
  bit              m_busy [NDut];
  bit              m_clr  [NDut];
  int unsigned     m_n    [NDut];
  bit              m_wr   [NDut];
  logic [SIZE-1:0] m_val  [NDut];
  logic [SIZE-1:0] m_adr  [NDut];

  function automatic bit exp_ready(int k);
    return m_busy[k] && !m_clr[k] && (m_n[k] < LayerSzs[k]);
  endfunction

  function automatic bit exp_done(int k);
    return m_busy[k] && (m_n[k] == LayerSzs[k]);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NDut; k++) begin
      m_busy[k] = 1'b0;
      m_clr[k]  = 1'b0;
      m_n[k]    = 0;
      m_wr[k]   = 1'b0;
      m_val[k]  = '0;
      m_adr[k]  = '0;
    end
  endtask

  // Advance the model across one rising edge, given the inputs that were present before it.
  task automatic model_edge(input bit s, input bit c, input bit v, input logic [SIZE-1:0] d);
    for (int k = 0; k < NDut; k++) begin
      if (!m_busy[k]) begin
        m_wr[k] = 1'b0;
        if (s) begin
          m_busy[k] = 1'b1;
          m_clr[k]  = c;
          m_n[k]    = 0;
        end
      end else begin
        m_wr[k] = exp_ready(k) && v;
        if (m_clr[k]) m_clr[k] = 1'b0;
        else if (m_n[k] == LayerSzs[k]) m_busy[k] = 1'b0;
        if (m_wr[k]) begin
          m_val[k] = d;
          m_adr[k] = SIZE'(m_n[k]);
          m_n[k]   = m_n[k] + 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string step);
    for (int k = 0; k < NDut; k++) begin
      chk($sformatf("%s.L%0d.in_ready", step, LayerSzs[k]), 32'(rdy[k]), 32'(exp_ready(k)));
      chk($sformatf("%s.L%0d.layer_reset", step, LayerSzs[k]), 32'(lrst[k]),
          32'(m_busy[k] && m_clr[k]));
      chk($sformatf("%s.L%0d.load_en", step, LayerSzs[k]), 32'(len[k]), 32'(m_wr[k]));
      chk($sformatf("%s.L%0d.busy", step, LayerSzs[k]), 32'(bsy[k]), 32'(m_busy[k]));
      chk($sformatf("%s.L%0d.done", step, LayerSzs[k]), 32'(dn[k]), 32'(exp_done(k)));
      chk($sformatf("%s.L%0d.load_value", step, LayerSzs[k]), 32'(val[k]), 32'(m_val[k]));
      chk($sformatf("%s.L%0d.load_address", step, LayerSzs[k]), 32'(adr[k]), 32'(m_adr[k]));
    end
  endtask

  // Called just after a falling edge: drive inputs, cross one rising edge, check at the next
  // falling edge.
  task automatic tick(input string step, input bit s, input bit c, input bit v,
                      input logic [SIZE-1:0] d);
    start = s;
    clr   = c;
    vld   = v;
    data  = d;
    @(posedge clk);
    model_edge(s, c, v, d);
    @(negedge clk);
    check_all(step);
  endtask

  task automatic idle(input string step, input int n);
    for (int i = 0; i < n; i++) tick(step, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  initial begin
    logic [SIZE-1:0] basic [4];
    bit              bub   [7];
    basic = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    bub   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    clr   = 1'b0;
    vld   = 1'b0;
    data  = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    idle("post_reset", 2);

    // Basic pass, no clear, valid held high.
    tick("basic_start", 1'b1, 1'b0, 1'b1, 16'h0000);
    for (int i = 0; i < 4; i++) tick("basic_load", 1'b0, 1'b0, 1'b1, basic[i]);
    idle("basic_tail", 3);

    // Clear first, then two values; larger layers keep waiting for more.
    tick("clear_start", 1'b1, 1'b1, 1'b0, 16'h0000);
    tick("clear_pulse", 1'b0, 1'b0, 1'b1, 16'hAAAA);
    tick("clear_load", 1'b0, 1'b0, 1'b1, 16'hAAAA);
    tick("clear_load", 1'b0, 1'b0, 1'b1, 16'h5555);
    tick("clear_fill", 1'b0, 1'b0, 1'b1, 16'h1234);
    tick("clear_fill", 1'b0, 1'b0, 1'b1, 16'h4321);
    idle("clear_tail", 3);

    // Upstream bubbles.
    tick("bubble_start", 1'b1, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 7; i++)
      tick("bubble_load", 1'b0, 1'b0, bub[i], 16'(16'h0100 + i));
    idle("bubble_tail", 3);

    // Start while busy must be ignored.
    tick("busy_start", 1'b1, 1'b0, 1'b1, 16'h0000);
    tick("busy_load", 1'b0, 1'b0, 1'b1, 16'hBEE0);
    tick("busy_restart", 1'b1, 1'b1, 1'b1, 16'hBEE1);
    tick("busy_load", 1'b0, 1'b0, 1'b1, 16'hBEE2);
    tick("busy_restart", 1'b1, 1'b0, 1'b1, 16'hBEE3);
    idle("busy_tail", 3);

    // Asynchronous reset after two writes, then a fresh pass from address 0.
    tick("rst_start", 1'b1, 1'b0, 1'b0, 16'h0000);
    tick("rst_load", 1'b0, 1'b0, 1'b1, 16'hC001);
    tick("rst_load", 1'b0, 1'b0, 1'b1, 16'hC002);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge clk);
    check_all("async_reset_hold");
    rst_n = 1'b1;
    tick("rst_restart", 1'b1, 1'b0, 1'b0, 16'h0000);
    tick("rst_reload", 1'b0, 1'b0, 1'b1, 16'h7FFF);
    for (int i = 0; i < 4; i++) tick("rst_reload", 1'b0, 1'b0, 1'b1, 16'(16'hD000 + i));
    idle("rst_tail", 3);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      tick("random", ($urandom_range(0, 5) == 0), 1'($urandom), ($urandom_range(0, 3) != 0),
           16'($urandom));
    end
    idle("final_tail", 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
